// File: rtl/bn_segment_pkg.sv
// Shared formats for the batch-norm/requantize stage.
// Fixed-point constants and saturation helpers.
package bn_segment_pkg;

    localparam int ACC_FRAC   = 14;
    localparam int FRAC_BITS  = 7;
    localparam int SCALE_FRAC = 8;

    localparam int     RQ_SHIFT  = ACC_FRAC + SCALE_FRAC - FRAC_BITS;
    localparam longint RQ_RND    = longint'(1) << (RQ_SHIFT - 1);
    localparam int     SCALE_ONE = 1 << SCALE_FRAC;

    function automatic longint sat_max(int w);
        return (longint'(1) << (w - 1)) - 1;
    endfunction

    function automatic longint sat_min(int w);
        return -(longint'(1) << (w - 1));
    endfunction

endpackage

// File: rtl/bn_coef_rf.sv
// Per-channel scale/bias register file.
// One registered write port, one combinational read port.
module bn_coef_rf
    import bn_segment_pkg::*;
#(
    parameter int NUM_CH      = 16,
    parameter int CH_BITS     = 4,
    parameter int SCALE_WIDTH = 16,
    parameter int DATA_WIDTH  = 26
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [CH_BITS-1:0]     waddr,
    input  logic [SCALE_WIDTH-1:0] wscale,
    input  logic [DATA_WIDTH-1:0]  wbias,
    input  logic [CH_BITS-1:0]     raddr,
    output logic [SCALE_WIDTH-1:0] rscale,
    output logic [DATA_WIDTH-1:0]  rbias
);

    logic [SCALE_WIDTH-1:0] scale_q [NUM_CH];
    logic [DATA_WIDTH-1:0]  bias_q  [NUM_CH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                scale_q[i] <= SCALE_WIDTH'(SCALE_ONE);
                bias_q[i]  <= '0;
            end
        end else if (we && (32'(waddr) < NUM_CH)) begin
            scale_q[waddr] <= wscale;
            bias_q[waddr]  <= wbias;
        end
    end

    // Reads see the pre-write contents in the write cycle.
    assign rscale = scale_q[raddr];
    assign rbias  = bias_q[raddr];

endmodule

// File: rtl/bn_segment.sv
// Batch-norm/requantize: acc*scale, round to Q.7, add bias, saturate.
// Four-stage pipeline, no backpressure.
module bn_segment
    import bn_segment_pkg::*;
#(
    parameter int ACC_WIDTH   = 32,
    parameter int DATA_WIDTH  = 26,
    parameter int SCALE_WIDTH = 16,
    parameter int NUM_CH      = 16,
    parameter int CH_BITS     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ACC_WIDTH-1:0]   acc_in,
    input  logic                   en,
    input  logic                   ch_clr,
    input  logic                   coef_we,
    input  logic [CH_BITS-1:0]     coef_addr,
    input  logic [SCALE_WIDTH-1:0] coef_scale,
    input  logic [DATA_WIDTH-1:0]  coef_bias,
    output logic [DATA_WIDTH-1:0]  output_data,
    output logic [CH_BITS-1:0]     ch_out,
    output logic                   valid
);

    localparam int PW    = ACC_WIDTH + SCALE_WIDTH;
    localparam int SUM_W = PW + 2;
    localparam logic signed [SUM_W-1:0] SMAX = SUM_W'(sat_max(DATA_WIDTH));
    localparam logic signed [SUM_W-1:0] SMIN = SUM_W'(sat_min(DATA_WIDTH));

    logic [CH_BITS-1:0]     ch_cnt, ch_sel, ch_nxt;
    logic [SCALE_WIDTH-1:0] rd_scale;
    logic [DATA_WIDTH-1:0]  rd_bias;

    logic                          s1_v, s2_v, s3_v;
    logic signed [ACC_WIDTH-1:0]   s1_acc;
    logic signed [SCALE_WIDTH-1:0] s1_scale;
    logic [DATA_WIDTH-1:0]         s1_bias, s2_bias;
    logic [CH_BITS-1:0]            s1_ch, s2_ch, s3_ch;
    logic signed [PW-1:0]          s2_prod;
    logic signed [SUM_W-1:0]       s3_sum;

    logic signed [PW:0]       prod_rnd, r;
    logic signed [SUM_W-1:0]  sum;
    logic [DATA_WIDTH-1:0]    sat;

    bn_coef_rf #(
        .NUM_CH      (NUM_CH),
        .CH_BITS     (CH_BITS),
        .SCALE_WIDTH (SCALE_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_rf (
        .clk    (clk),
        .rst    (rst),
        .we     (coef_we),
        .waddr  (coef_addr),
        .wscale (coef_scale),
        .wbias  (coef_bias),
        .raddr  (ch_sel),
        .rscale (rd_scale),
        .rbias  (rd_bias)
    );

    // ch_clr with en makes the current sample use channel 0.
    always_comb begin
        ch_sel = ch_clr ? '0 : ch_cnt;
        ch_nxt = ch_sel;
        if (en) begin
            if (32'(ch_sel) == NUM_CH - 1) ch_nxt = '0;
            else                            ch_nxt = ch_sel + 1'b1;
        end
    end

    always_comb begin
        prod_rnd = {s2_prod[PW-1], s2_prod} + (PW+1)'(RQ_RND);
        r        = prod_rnd >>> RQ_SHIFT;
        sum      = {r[PW], r}
                 + {{(SUM_W-DATA_WIDTH){s2_bias[DATA_WIDTH-1]}}, s2_bias};
    end

    always_comb begin
        if (s3_sum > SMAX)      sat = SMAX[DATA_WIDTH-1:0];
        else if (s3_sum < SMIN) sat = SMIN[DATA_WIDTH-1:0];
        else                    sat = s3_sum[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch_cnt      <= '0;
            s1_v        <= 1'b0;
            s2_v        <= 1'b0;
            s3_v        <= 1'b0;
            valid       <= 1'b0;
            s1_acc      <= '0;
            s1_scale    <= '0;
            s1_bias     <= '0;
            s1_ch       <= '0;
            s2_prod     <= '0;
            s2_bias     <= '0;
            s2_ch       <= '0;
            s3_sum      <= '0;
            s3_ch       <= '0;
            output_data <= '0;
            ch_out      <= '0;
        end else begin
            ch_cnt <= ch_nxt;
            s1_v   <= en;
            s2_v   <= s1_v;
            s3_v   <= s2_v;
            valid  <= s3_v;
            if (en) begin
                s1_acc   <= acc_in;
                s1_scale <= rd_scale;
                s1_bias  <= rd_bias;
                s1_ch    <= ch_sel;
            end
            if (s1_v) begin
                s2_prod <= $signed({{SCALE_WIDTH{s1_acc[ACC_WIDTH-1]}}, s1_acc})
                         * $signed({{ACC_WIDTH{s1_scale[SCALE_WIDTH-1]}}, s1_scale});
                s2_bias <= s1_bias;
                s2_ch   <= s1_ch;
            end
            if (s2_v) begin
                s3_sum <= sum;
                s3_ch  <= s2_ch;
            end
            if (s3_v) begin
                output_data <= sat;
                ch_out      <= s3_ch;
            end
        end
    end

endmodule

// File: tb/tb_bn_segment.sv
// Directed self-checking bench for bn_segment.
// Four-channel build so channel wrap is exercised.
module tb_bn_segment;

    localparam int AW = 32;
    localparam int DW = 26;
    localparam int SW = 16;
    localparam int NC = 4;
    localparam int CB = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] acc_in = '0;
    logic          en = 1'b0;
    logic          ch_clr = 1'b0;
    logic          coef_we = 1'b0;
    logic [CB-1:0] coef_addr = '0;
    logic [SW-1:0] coef_scale = '0;
    logic [DW-1:0] coef_bias = '0;
    logic [DW-1:0] output_data;
    logic [CB-1:0] ch_out;
    logic          valid;

    int checks = 0;
    int errors = 0;

    int acc_v [8];
    int en_v  [8];
    int clr_v [8];
    int we_v  [8];
    int wa_v  [8];
    int ws_v  [8];
    int ed_v  [8];
    int ec_v  [8];

    bn_segment #(
        .ACC_WIDTH   (AW),
        .DATA_WIDTH  (DW),
        .SCALE_WIDTH (SW),
        .NUM_CH      (NC),
        .CH_BITS     (CB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .acc_in      (acc_in),
        .en          (en),
        .ch_clr      (ch_clr),
        .coef_we     (coef_we),
        .coef_addr   (coef_addr),
        .coef_scale  (coef_scale),
        .coef_bias   (coef_bias),
        .output_data (output_data),
        .ch_out      (ch_out),
        .valid       (valid)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_data(string tag, int exp);
        logic [DW-1:0] e;
        e = exp[DW-1:0];
        checks++;
        assert (output_data === e) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag,
                   $signed(output_data), exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en      = 1'b0;
        ch_clr  = 1'b0;
        coef_we = 1'b0;
    endtask

    task automatic wr(int a, int s, int b);
        idle();
        coef_we    = 1'b1;
        coef_addr  = CB'(a);
        coef_scale = SW'(s);
        coef_bias  = DW'(b);
        tick();
        coef_we = 1'b0;
    endtask

    task automatic sv(int i, int a, int e, int c, int w,
                      int wa, int ws, int ed, int ec);
        acc_v[i] = a;  en_v[i] = e;  clr_v[i] = c;
        we_v[i]  = w;  wa_v[i] = wa; ws_v[i]  = ws;
        ed_v[i]  = ed; ec_v[i] = ec;
    endtask

    // Sample j is driven in iteration j and seen after iteration j+3.
    task automatic run(int n, string tag);
        for (int i = 0; i < n + 3; i++) begin
            if (i < n) begin
                acc_in     = AW'(acc_v[i]);
                en         = en_v[i][0];
                ch_clr     = clr_v[i][0];
                coef_we    = we_v[i][0];
                coef_addr  = CB'(wa_v[i]);
                coef_scale = SW'(ws_v[i]);
                coef_bias  = '0;
            end else begin
                idle();
            end
            tick();
            if (i < 3) begin
                chk($sformatf("%s_early_valid%0d", tag, i), int'(valid), 0);
            end else begin
                chk($sformatf("%s_valid%0d", tag, i - 3),
                    int'(valid), en_v[i-3]);
                if (en_v[i-3] != 0) begin
                    chk_data($sformatf("%s_data%0d", tag, i - 3), ed_v[i-3]);
                    chk($sformatf("%s_ch%0d", tag, i - 3),
                        int'(ch_out), ec_v[i-3]);
                end
            end
        end
    endtask

    initial begin
        idle();
        tick();
        tick();
        chk("rst_valid", int'(valid), 0);
        chk_data("rst_data", 0);
        chk("rst_ch", int'(ch_out), 0);
        rst = 1'b1;
        tick();

        sv(0, 16384, 1, 0, 0, 0, 0, 128, 0);
        run(1, "ident");

        wr(0, 256, 1536);
        sv(0, -16384, 1, 1, 0, 0, 0, 1408, 0);
        sv(1, 64,     1, 1, 0, 0, 0, 1537, 0);
        sv(2, -64,    1, 1, 0, 0, 0, 1536, 0);
        run(3, "bias");

        wr(0, 32767, 0);
        sv(0, 32'h7fffffff, 1, 1, 0, 0, 0, 33554431, 0);
        sv(1, 32'h80000000, 1, 1, 0, 0, 0, -33554432, 0);
        run(2, "sat");

        wr(0, 256, 0);
        wr(1, 512, 0);
        wr(2, 128, 0);
        wr(3, -256, 0);
        sv(0, 16384, 1, 1, 0, 0, 0, 128, 0);
        sv(1, 16384, 1, 0, 0, 0, 0, 256, 1);
        sv(2, 16384, 1, 0, 0, 0, 0, 64, 2);
        sv(3, 16384, 1, 0, 0, 0, 0, -128, 3);
        sv(4, 16384, 1, 0, 0, 0, 0, 128, 0);
        run(5, "wrap");

        sv(0, 16384, 1, 1, 0, 0, 0, 128, 0);
        sv(1, 16384, 1, 0, 0, 0, 0, 256, 1);
        sv(2, 16384, 1, 1, 0, 0, 0, 128, 0);
        sv(3, 16384, 1, 0, 0, 0, 0, 256, 1);
        run(4, "clr");

        wr(1, 128, 0);
        sv(0, 16384, 1, 1, 0, 0, 0,   128, 0);
        sv(1, 16384, 1, 0, 1, 1, 512, 64,  1);
        sv(2, 0,     0, 0, 0, 0, 0,   0,   0);
        sv(3, 16384, 1, 0, 0, 0, 0,   64,  2);
        sv(4, 16384, 1, 0, 0, 0, 0,   -128, 3);
        sv(5, 16384, 1, 0, 0, 0, 0,   128, 0);
        sv(6, 16384, 1, 0, 0, 0, 0,   256, 1);
        run(7, "hazard");

        for (int i = 0; i < 3; i++) begin
            acc_in = AW'(32768);
            en     = 1'b1;
            tick();
        end
        idle();
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", int'(valid), 0);
        chk_data("mid_rst_data", 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("mid_rst_hold_valid%0d", i), int'(valid), 0);
            chk_data($sformatf("mid_rst_hold_data%0d", i), 0);
        end
        rst = 1'b1;
        tick();
        sv(0, 16384, 1, 0, 0, 0, 0, 128, 0);
        sv(1, 16384, 1, 0, 0, 0, 0, 128, 1);
        run(2, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bn_segment.md
Name: bn_segment

Overview:
- Per-channel batch-norm/requantize stage; sits directly upstream of the hard-swish segment.
- Consumes raw convolution accumulators and applies a per-channel scale and bias.
- Rounds and saturates to the 26-bit Q.7 activation format the hard-swish stage expects.
- `output_data`/`valid` connect straight to the hard-swish `input_data`/`en`.

Parameters:
- ACC_WIDTH, 32, signed accumulator width, Q.14 (ACC_FRAC=14 fixed)
- DATA_WIDTH, 26, signed output width, Q.7 (FRAC_BITS=7)
- SCALE_WIDTH, 16, signed scale width, Q.8 (SCALE_FRAC=8)
- NUM_CH, 16, number of channels held in the coefficient register file (>=2)
- CH_BITS, 4, clog2(NUM_CH)

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-low reset
- acc_in  input  ACC_WIDTH  signed accumulator sample, Q.14
- en  input  1  acc_in valid this cycle
- ch_clr  input  1  synchronous clear of the channel counter
- coef_we  input  1  coefficient write strobe
- coef_addr  input  CH_BITS  channel index to write
- coef_scale  input  SCALE_WIDTH  signed scale, Q.8
- coef_bias  input  DATA_WIDTH  signed bias, Q.7
- output_data  output  DATA_WIDTH  signed result, Q.7
- ch_out  output  CH_BITS  channel index aligned with output_data
- valid  output  1  output_data valid

Behaviour:
- Clock and reset:
  - One clock: clk.
  - Reset rst is asynchronous and active-low.
  - Reset values: output_data=0, ch_out=0, valid=0, all stage valids 0, channel counter 0.
  - Reset sets every coefficient entry to scale=256 (1.0), bias=0.
- Flow control:
  - No backpressure; one sample accepted per cycle when en=1.
  - Latency is fixed at 4 cycles: en at cycle N gives valid at N+4.
  - Gaps in en propagate as gaps in valid.
- S1 (fetch):
  - Register acc_in together with scale[ch_cnt], bias[ch_cnt] and ch_cnt.
  - ch_cnt increments on each accepted sample.
  - ch_cnt wraps from NUM_CH-1 to 0.
- S2 (multiply):
  - prod = acc * scale, full width ACC_WIDTH+SCALE_WIDTH signed, Q.22.
- S3 (round/add):
  - r = (prod + 2^14) >>> 15, arithmetic shift giving Q.7; rounding is round-half-up (towards +inf).
  - sum = r + sign-extended bias.
  - Intermediates are wide enough that none overflows.
- S4 (saturate):
  - Clamp sum to [-2^25, 2^25-1].
  - Drive output_data, ch_out and valid=1.
  - valid=0 when no sample is in S4; output_data holds its last value (not zeroed).
- ch_clr:
  - Sets ch_cnt=0 next cycle.
  - If en and ch_clr are high together, the current sample uses channel 0 and the counter becomes 1.
  - In-flight samples are unaffected.
- Coefficient writes:
  - Registered writes, usable at any time, including while streaming.
  - A write to the entry S1 reads in the same cycle: S1 takes the old value (read-before-write); the new value applies from the next cycle.
  - coef_addr >= NUM_CH: write ignored.
- Reset mid-stream: all in-flight samples are discarded with no valid pulse; coefficients return to identity.

Decomposition:
- Shared package holds:
  - Format constants ACC_FRAC=14, FRAC_BITS=7, SCALE_FRAC=8.
  - Derived shift RQ_SHIFT=ACC_FRAC+SCALE_FRAC-FRAC_BITS=15 and rounding constant 2^(RQ_SHIFT-1).
  - Saturation limits SAT_MAX/SAT_MIN as functions of DATA_WIDTH.
  - Identity scale value 256.
- One natural sub-module, bn_coef_rf: NUM_CH-entry scale/bias register file.
  - Async reset to identity.
  - One write port, one combinational read port.
- Pipeline and counter stay in bn_segment.

Test Plan:
- Identity pass (coefficients at reset), acc=16384 (1.0) on ch0 -> output_data=128, ch_out=0, valid exactly 4 cycles after en.
- ch0 scale=256, bias=1536; acc=-16384 -> 1408; acc=64 -> 1537 (half rounds up); acc=-64 -> 1536.
- Saturation: scale=32767, bias=0, acc=2^31-1 -> 33554431; acc=-2^31 -> -33554432.
- NUM_CH=4, scales {256,512,128,-256}, biases 0; 5 back-to-back samples acc=16384 -> outputs 128,256,64,-128,128 with ch_out 0,1,2,3,0; ch_clr pulsed with the 3rd sample -> its ch_out=0.
- Streaming write hazard: coef_we to ch1 (scale=512) in the same cycle S1 reads ch1 -> that sample uses the old scale (128); the next ch1 sample uses 256 for acc=16384.
- Reset asserted with 3 samples in flight -> valid stays 0, output_data=0; first sample after release uses ch0 with identity coefficients.
